// File: rtl/ddr3_arb_pkg.sv
// ddr3_arb_pkg: shared command encodings, beat geometry and FSM state type for the DDR3 port arbiter
package ddr3_arb_pkg;
    localparam logic DDR_CMD_WR = 1'b0;
    localparam logic DDR_CMD_RD = 1'b1;
    localparam int BEAT_OFFSET_BITS = 5;
    typedef enum logic {IDLE, ISSUE} arb_state_e;
endpackage

// File: rtl/ddr3_arb_tag_fifo.sv
// ddr3_arb_tag_fifo: in-order FIFO of issuing-port tags for reads in flight
module ddr3_arb_tag_fifo #(
    parameter int W          = 1,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic                push,
    input  logic [W-1:0]        push_data,
    input  logic                pop,
    output logic [W-1:0]        head,
    output logic                full,
    output logic                empty,
    output logic [DEPTH_LOG2:0] count
);
    localparam int CW = DEPTH_LOG2 + 1;
    logic [W-1:0] mem [2**DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic wr, rd;
    assign full  = count == CW'(2**DEPTH_LOG2);
    assign empty = count == '0;
    assign rd    = pop & ~empty;
    assign wr    = push & (~full | rd);
    assign head  = mem[rd_ptr];
    // Tag storage; contents are don't-care until written
    always_ff @(posedge aclk) begin
        if (wr) mem[wr_ptr] <= push_data;
    end
    // Pointers and occupancy; a simultaneous push and pop leaves the count unchanged
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr) wr_ptr <= wr_ptr + 1'b1;
            if (rd) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(wr) - CW'(rd);
        end
    end
endmodule

// File: rtl/ddr3_port_arbiter.sv
// ddr3_port_arbiter: round-robin sharing of one DDR3 command/data port with in-order read return routing
module ddr3_port_arbiter
    import ddr3_arb_pkg::*;
#(
    parameter int NUM_PORTS      = 2,
    parameter int TAG_DEPTH_LOG2 = 3,
    parameter int ADDR_W         = 29,
    parameter int DATA_W         = 256
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic                          init_calib_complete,
    input  logic [NUM_PORTS-1:0]          req_valid,
    output logic [NUM_PORTS-1:0]          req_ready,
    input  logic [NUM_PORTS-1:0]          req_we,
    input  logic [NUM_PORTS*ADDR_W-1:0]   req_addr,
    input  logic [NUM_PORTS*DATA_W-1:0]   req_wdata,
    input  logic [NUM_PORTS*DATA_W/8-1:0] req_be,
    output logic [NUM_PORTS-1:0]          rsp_valid,
    output logic [DATA_W-1:0]             rsp_data,
    input  logic                          ddr_cmd_ready,
    input  logic                          ddr_wr_data_ready,
    output logic                          ddr_cmd_en,
    output logic                          ddr_cmd,
    output logic [ADDR_W-1:0]             ddr_cmd_addr,
    output logic [DATA_W-1:0]             ddr_wr_data,
    output logic [DATA_W/8-1:0]           ddr_wr_strb,
    input  logic                          ddr_rd_data_valid,
    input  logic [DATA_W-1:0]             ddr_rd_data,
    output logic [TAG_DEPTH_LOG2:0]       rd_outstanding,
    output logic                          err_unexpected_rd
);
    localparam int PW = $clog2(NUM_PORTS);
    localparam int BW = DATA_W / 8;
    localparam int HW = ADDR_W - BEAT_OFFSET_BITS;

    arb_state_e state, state_nxt;
    logic [PW-1:0] ptr, pick, head, port_r;
    logic [NUM_PORTS-1:0] elig;
    logic any, grant, issue, push, pop, fifo_full, fifo_empty;
    logic we_r;
    logic [HW-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic [BW-1:0] be_r;

    // Eligible ports and round-robin pick; scanning down from the farthest offset lets the nearest one win
    always_comb begin
        any  = 1'b0;
        pick = ptr;
        for (int i = 0; i < NUM_PORTS; i++)
            elig[i] = req_valid[i] & init_calib_complete & (req_we[i] | ~fifo_full);
        for (int i = NUM_PORTS - 1; i >= 0; i--)
            if (elig[(int'(ptr) + i) % NUM_PORTS]) begin
                any  = 1'b1;
                pick = PW'((int'(ptr) + i) % NUM_PORTS);
            end
    end

    // Next state plus grant, command and tag-FIFO strobes; command fields read as zero outside ISSUE
    always_comb begin
        issue        = state == ISSUE;
        grant        = (state == IDLE) & any;
        req_ready    = grant ? (NUM_PORTS'(1) << pick) : '0;
        ddr_cmd_en   = issue & ddr_cmd_ready & (~we_r | ddr_wr_data_ready);
        ddr_cmd      = issue ? (we_r ? DDR_CMD_WR : DDR_CMD_RD) : 1'b0;
        ddr_cmd_addr = issue ? {addr_r, {BEAT_OFFSET_BITS{1'b0}}} : '0;
        ddr_wr_data  = issue ? wdata_r : '0;
        ddr_wr_strb  = issue ? ~be_r : '0;
        push         = ddr_cmd_en & ~we_r;
        pop          = ddr_rd_data_valid & ~fifo_empty;
        state_nxt    = grant ? ISSUE : (ddr_cmd_en ? IDLE : state);
    end

    // State register and round-robin pointer, which moves just past the granted port
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            if (grant) ptr <= (int'(pick) == NUM_PORTS - 1) ? '0 : pick + 1'b1;
        end
    end

    // Command register captured from the granted port; only beat-aligned address bits are kept
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            we_r    <= 1'b0;
            addr_r  <= '0;
            wdata_r <= '0;
            be_r    <= '0;
            port_r  <= '0;
        end else if (grant) begin
            we_r    <= req_we[pick];
            addr_r  <= req_addr[int'(pick)*ADDR_W + BEAT_OFFSET_BITS +: HW];
            wdata_r <= req_wdata[int'(pick)*DATA_W +: DATA_W];
            be_r    <= req_be[int'(pick)*BW +: BW];
            port_r  <= pick;
        end
    end

    // Read return: route each beat to the head tag one cycle later; a beat with nothing in flight is dropped and flagged
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rsp_valid         <= '0;
            rsp_data          <= '0;
            err_unexpected_rd <= 1'b0;
        end else begin
            rsp_valid         <= pop ? (NUM_PORTS'(1) << head) : '0;
            if (pop) rsp_data <= ddr_rd_data;
            err_unexpected_rd <= err_unexpected_rd | (ddr_rd_data_valid & fifo_empty);
        end
    end

    ddr3_arb_tag_fifo #(
        .W          (PW),
        .DEPTH_LOG2 (TAG_DEPTH_LOG2)
    ) u_tag_fifo (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .push      (push),
        .push_data (port_r),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (rd_outstanding)
    );
endmodule
